// File: rtl/crc_mm_engine_if.sv
// Register-window bus for crc_mm_engine: strobed host reads/writes plus the result mirror output.
// The host side uses the master modport, the engine the slave modport.
interface crc_mm_engine_if;
  logic        swr;
  logic        srd;
  logic [16:0] saddress;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  logic [31:0] gpio_out;

  modport master (output swr, srd, saddress, sdata_in, input sdata_out, gpio_out);
  modport slave  (input swr, srd, saddress, sdata_in, output sdata_out, gpio_out);
endinterface

// File: rtl/crc_mm_engine.sv
// Bus-mapped CRC-32 / CRC-32C engine: byte FIFO, IDLE/LOAD/SHIFT/FINAL sequencer, status and result registers.
// Optional feature CRC_GPIO_MIRROR_EN: when defined, gpio_out mirrors RESULT; otherwise gpio_out is tied to 0.
module crc_mm_engine #(
  parameter logic [16:0] ADDR_BASE    = 17'h00680,
  parameter int          DEPTH        = 16,
  parameter int          BITS_PER_CLK = 1
) (
  input  logic           clk,
  input  logic           n_reset,
  crc_mm_engine_if.slave bus
);
  localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [3:0]  SHIFT_LAST = 4'(8 / BITS_PER_CLK - 1);
  localparam logic [31:0] POLY_CRC32  = 32'hEDB88320;
  localparam logic [31:0] POLY_CRC32C = 32'h82F63B78;
  localparam logic [16:0] A_IN     = ADDR_BASE;
  localparam logic [16:0] A_STATE  = ADDR_BASE + 17'h8;
  localparam logic [16:0] A_RESULT = ADDR_BASE + 17'h10;
  localparam logic [16:0] A_CTRL   = ADDR_BASE + 17'h18;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FINAL} state_t;

  // Reflected (LSB-first) fold of BITS_PER_CLK message bits into the CRC register.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [7:0] data,
                                           input logic [31:0] poly);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < BITS_PER_CLK; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ poly;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mode_q, mode_d;
  logic [31:0] sdata_out_q, sdata_out_d;
  logic [7:0]  mem [DEPTH];
  logic        push_en;
`ifdef CRC_GPIO_MIRROR_EN
  logic [31:0] gpio_q, gpio_d;
`endif

  logic        busy, full, empty, wr_in, wr_ctrl;
  logic [7:0]  cmd;
  logic [31:0] poly, status;
  logic [23:0] unused_wdata;

  assign busy    = (state_q != S_IDLE);
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_in   = bus.swr && (bus.saddress == A_IN);
  assign wr_ctrl = bus.swr && (bus.saddress == A_CTRL);
  assign cmd     = bus.sdata_in[7:0];
  assign poly    = mode_q ? POLY_CRC32C : POLY_CRC32;
  assign status  = {16'(count_q), 10'b0, mode_q, err_q, empty, full, done_q, busy};
  assign unused_wdata = bus.sdata_in[31:8];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    bit_cnt_d   = bit_cnt_q;
    crc_d       = crc_q;
    shreg_d     = shreg_q;
    result_d    = result_q;
    done_d      = done_q;
    err_d       = err_q;
    mode_d      = mode_q;
    push_en     = 1'b0;
`ifdef CRC_GPIO_MIRROR_EN
    gpio_d      = gpio_q;
`endif
    sdata_out_d = sdata_out_q;

    // Reads sample the pre-edge state, so a read never sees the effect of a same-cycle write.
    if (bus.srd) begin
      case (bus.saddress)
        A_STATE:  sdata_out_d = status;
        A_RESULT: sdata_out_d = result_q;
        default:  sdata_out_d = '0;
      endcase
    end

    if (wr_ctrl && cmd == 8'h0A) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      result_d = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
`ifdef CRC_GPIO_MIRROR_EN
      gpio_d   = '0;
`endif
    end else begin
      if (wr_in) begin
        if (full || busy) begin
          err_d = 1'b1;
        end else begin
          push_en  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
      end
      if (wr_ctrl && !busy) begin
        if (cmd == 8'h0C) mode_d = 1'b0;
        if (cmd == 8'h0D) mode_d = 1'b1;
      end

      // Pushes are only accepted in IDLE and pops only happen in LOAD, so count never moves both ways.
      case (state_q)
        S_IDLE: begin
          if (wr_ctrl && cmd == 8'h0B) begin
            crc_d   = 32'hFFFF_FFFF;
            done_d  = 1'b0;
            state_d = empty ? S_FINAL : S_LOAD;
          end
        end
        S_LOAD: begin
          shreg_d   = mem[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + 1'b1;
          count_d   = count_q - 1'b1;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
        S_SHIFT: begin
          crc_d     = crc_fold(crc_q, shreg_q, poly);
          shreg_d   = shreg_q >> BITS_PER_CLK;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == SHIFT_LAST) state_d = empty ? S_FINAL : S_LOAD;
        end
        default: begin
          result_d = ~crc_q;
          done_d   = 1'b1;
`ifdef CRC_GPIO_MIRROR_EN
          gpio_d   = ~crc_q;
`endif
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bit_cnt_q   <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mode_q      <= 1'b0;
      sdata_out_q <= '0;
`ifdef CRC_GPIO_MIRROR_EN
      gpio_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bit_cnt_q   <= bit_cnt_d;
      result_q    <= result_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      sdata_out_q <= sdata_out_d;
`ifdef CRC_GPIO_MIRROR_EN
      gpio_q      <= gpio_d;
`endif
    end
  end

  // Datapath storage is always overwritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    crc_q   <= crc_d;
    shreg_q <= shreg_d;
    if (push_en) mem[wr_ptr_q] <= bus.sdata_in[7:0];
  end

  assign bus.sdata_out = sdata_out_q;
`ifdef CRC_GPIO_MIRROR_EN
  assign bus.gpio_out  = gpio_q;
`else
  assign bus.gpio_out  = '0;
`endif
endmodule

// File: tb/tb_crc_mm_engine.sv
// Bench for crc_mm_engine: table of known CRC vectors plus hand-written sequences for
// busy/full/clear/reset corners; register reads are checked through an expected-value queue.
module tb_crc_mm_engine;
  localparam int          DEPTH    = 16;
  localparam int          BPC      = 1;
  localparam logic [16:0] BASE     = 17'h00680;
  localparam logic [16:0] A_IN     = BASE;
  localparam logic [16:0] A_STATE  = BASE + 17'h8;
  localparam logic [16:0] A_RESULT = BASE + 17'h10;
  localparam logic [16:0] A_CTRL   = BASE + 17'h18;
  localparam logic [71:0] MSG_DIGITS = 72'h393837363534333231;  // "123456789", first byte in [7:0]

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic raw_rd = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  crc_mm_engine_if bus();

  crc_mm_engine #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .BITS_PER_CLK(BPC)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mode;
    logic [3:0]  len;
    logic [71:0] data;
    logic [31:0] crc;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  function automatic logic [31:0] st(input logic busy, input logic done, input logic full,
                                     input logic empty, input logic err, input logic mode,
                                     input int cnt);
    return {16'(cnt), 10'b0, mode, err, empty, full, done, busy};
  endfunction

  // Scoreboard consumer: every checked read pops one expected value.
  always @(posedge clk) begin
    if (bus.srd && !raw_rd) begin
      #1;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: read at %0t with no expected value queued", $time);
      end else begin
        check(nm_q.pop_front(), bus.sdata_out, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [16:0] a, input logic [31:0] d);
    @(negedge clk); bus.swr = 1'b1; bus.saddress = a; bus.sdata_in = d;
    @(negedge clk); bus.swr = 1'b0;
  endtask

  task automatic rd_chk(input logic [16:0] a, input logic [31:0] e, input string nm);
    @(negedge clk); bus.srd = 1'b1; bus.saddress = a; exp_q.push_back(e); nm_q.push_back(nm);
    @(negedge clk); bus.srd = 1'b0;
  endtask

  task automatic wr_then_rd(input logic [16:0] wa, input logic [31:0] wd, input logic [16:0] ra,
                            input logic [31:0] e, input string nm);
    @(negedge clk); bus.swr = 1'b1; bus.saddress = wa; bus.sdata_in = wd;
    @(negedge clk); bus.swr = 1'b0; bus.srd = 1'b1; bus.saddress = ra;
    exp_q.push_back(e); nm_q.push_back(nm);
    @(negedge clk); bus.srd = 1'b0;
  endtask

  task automatic push_msg(input logic [71:0] d, input int n);
    for (int b = 0; b < n; b++) wr(A_IN, {24'h0, d[8*b +: 8]});
  endtask

  // Optionally issue start, then read STATE every cycle until DONE, bounded.
  task automatic poll_done(input bit do_start, output int cyc, output logic busy1);
    bit seen;
    seen = 1'b0;
    busy1 = 1'b0;
    if (do_start) begin
      @(negedge clk); bus.swr = 1'b1; bus.saddress = A_CTRL; bus.sdata_in = 32'h0B;
    end
    @(negedge clk); bus.swr = 1'b0; raw_rd = 1'b1; bus.srd = 1'b1; bus.saddress = A_STATE;
    cyc = 0;
    while (!seen && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) busy1 = bus.sdata_out[0];
      seen = bus.sdata_out[1];
    end
    @(negedge clk); bus.srd = 1'b0; raw_rd = 1'b0;
    if (!seen) begin
      n_total++;
      $display("FAIL done_timeout: DONE not seen after %0d cycles", cyc);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   lat;
    logic b1;
    v = vecs[i];
    wr(A_CTRL, 32'h0A);
    wr(A_CTRL, v.mode ? 32'h0D : 32'h0C);
    push_msg(v.data, int'(v.len));
    rd_chk(A_STATE, st(0, 0, v.len == DEPTH, v.len == 0, 0, v.mode, int'(v.len)),
           $sformatf("vec%0d_fill", i));
    poll_done(1'b1, lat, b1);
    check($sformatf("vec%0d_busy_at_e1", i), 32'(b1), 32'd1);
    check($sformatf("vec%0d_latency", i), lat, 2 + int'(v.len) * (1 + 8 / BPC));
    rd_chk(A_RESULT, v.crc, $sformatf("vec%0d_result", i));
    rd_chk(A_STATE, st(0, 1, 0, 1, 0, v.mode, 0), $sformatf("vec%0d_state_done", i));
`ifdef CRC_GPIO_MIRROR_EN
    check($sformatf("vec%0d_gpio", i), bus.gpio_out, v.crc);
`else
    check($sformatf("vec%0d_gpio", i), bus.gpio_out, 32'h0);
`endif
  endtask

  initial begin
    int   lat;
    logic b1;
    bus.swr = 1'b0; bus.srd = 1'b0; bus.saddress = '0; bus.sdata_in = '0;
    vecs[0] = '{mode: 1'b0, len: 4'd9, data: MSG_DIGITS, crc: 32'hCBF43926};
    vecs[1] = '{mode: 1'b1, len: 4'd9, data: MSG_DIGITS, crc: 32'hE3069283};
    vecs[2] = '{mode: 1'b0, len: 4'd1, data: 72'h00,     crc: 32'hD202EF8D};
    vecs[3] = '{mode: 1'b0, len: 4'd0, data: 72'h00,     crc: 32'h00000000};
    vecs[4] = '{mode: 1'b0, len: 4'd1, data: 72'h61,     crc: 32'hE8B7BE43};

    repeat (3) @(negedge clk);
    check("rst_sdata_out", bus.sdata_out, 32'h0);
    check("rst_gpio_out", bus.gpio_out, 32'h0);
    n_reset = 1'b1;
    rd_chk(A_STATE, 32'h00000008, "rst_state");
    rd_chk(A_RESULT, 32'h0, "rst_result");

    // Unmapped writes must not act as clear or push; unmapped and write-only reads return 0.
    wr(A_IN, 32'h11);
    wr(BASE + 17'h20, 32'h0A);
    wr(BASE + 17'h1, 32'h22);
    rd_chk(A_STATE, st(0, 0, 0, 0, 0, 0, 1), "unmapped_wr_state");
    rd_chk(BASE + 17'h4, 32'h0, "unmapped_rd");
    rd_chk(A_CTRL, 32'h0, "ctrl_rd_zero");

    for (int i = 0; i < 5; i++) run_vec(i);

    // Clear during SHIFT after a completed run: RESULT and DONE drop, MODE survives.
    wr(A_CTRL, 32'h0D);
    push_msg(MSG_DIGITS, 9);
    wr(A_CTRL, 32'h0B);
    repeat (3) @(negedge clk);
    wr_then_rd(A_CTRL, 32'h0A, A_STATE, st(0, 0, 0, 1, 0, 1, 0), "clear_mid_state");
    rd_chk(A_RESULT, 32'h0, "clear_mid_result");
    check("clear_mid_gpio", bus.gpio_out, 32'h0);
    run_vec(0);

    // Push and mode change while busy are rejected; the run completes unaffected.
    wr(A_CTRL, 32'h0A);
    push_msg(MSG_DIGITS, 9);
    wr(A_CTRL, 32'h0B);
    wr(A_IN, 32'h55);
    wr(A_CTRL, 32'h0D);
    poll_done(1'b0, lat, b1);
    rd_chk(A_RESULT, 32'hCBF43926, "busy_push_result");
    rd_chk(A_STATE, st(0, 1, 0, 1, 1, 0, 0), "busy_push_state");

    // Overfill by one byte.
    wr(A_CTRL, 32'h0A);
    for (int i = 0; i <= DEPTH; i++) wr(A_IN, 32'(i));
    rd_chk(A_STATE, st(0, 0, 1, 0, 1, 0, DEPTH), "full_state");
    rd_chk(A_RESULT, 32'h0, "full_result_cleared");

    // Asynchronous reset in the middle of a run.
    wr(A_CTRL, 32'h0A);
    wr(A_CTRL, 32'h0D);
    push_msg(MSG_DIGITS, 9);
    wr(A_CTRL, 32'h0B);
    repeat (4) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("midrst_sdata_out", bus.sdata_out, 32'h0);
    check("midrst_gpio_out", bus.gpio_out, 32'h0);
    @(negedge clk); n_reset = 1'b1;
    rd_chk(A_STATE, 32'h00000008, "midrst_state");
    rd_chk(A_RESULT, 32'h0, "midrst_result");
    run_vec(0);

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
